// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the TDM serial receive path.
//   state_t     - receiver alignment state (HUNT while searching, LOCKED once aligned)
//   TDM_NUM_CH  - default number of channels per frame
//   TDM_SLOT_W  - slot index width for the default channel count
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int TDM_NUM_CH = 4;
    localparam int TDM_SLOT_W = $clog2(TDM_NUM_CH);

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-NUM_CH slot index for the TDM receiver.
//   clk, rst_n - clock and asynchronous active-low reset
//   en         - advance slot by one (wraps NUM_CH-1 -> 0)
//   load1      - synchronous realign: slot <= 1 (bit just taken was ch0)
//   clr        - synchronous clear: slot <= 0 (takes priority over load1/en)
//   slot       - index of the next expected slot
//   last       - slot is the frame-completion slot (NUM_CH-1)
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = TDM_NUM_CH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load1,
    input  logic                      clr,
    output logic [$clog2(NUM_CH)-1:0] slot,
    output logic                      last
);

    localparam int SLOT_W = $clog2(NUM_CH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (en) begin
            // NUM_CH is a power of two, so natural overflow is the modulo wrap.
            slot <= slot + 1'b1;
        end
    end

    assign last = (slot == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: receive end of the NUM_CH-channel TDM serial link.
// Recovers frame alignment from the slot-0 sync marker, collects one bit per
// slot and publishes each complete frame as a registered parallel word.
//   clk, rst_n  - clock and asynchronous active-low reset
//   en          - bit strobe; data/sync are only looked at when en=1
//   data        - serial channel bit for the current slot
//   sync        - frame marker, expected together with the slot-0 bit
//   q           - last complete frame, q[i] = channel i
//   frame_valid - one-cycle pulse when q updates
//   locked      - frame alignment held
//   sync_err    - one-cycle pulse on a sync seen outside slot 0
//   slot        - index of the next expected slot
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int NUM_CH     = TDM_NUM_CH,
    parameter int MISS_LIMIT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      data,
    input  logic                      sync,
    output logic [NUM_CH-1:0]         q,
    output logic                      frame_valid,
    output logic                      locked,
    output logic                      sync_err,
    output logic [$clog2(NUM_CH)-1:0] slot
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    state_t              state, state_nxt;
    logic [MISS_W-1:0]   miss_cnt;
    logic [NUM_CH-2:0]   sr;          // ch0..ch(NUM_CH-2) of the frame in progress
    logic [NUM_CH-2:0]   sr_shifted;

    logic slot_last, slot_zero, miss_at_limit;

    // Per-strobe control decisions, all zero when en=0.
    logic slot_adv, slot_load1, slot_clr;
    logic shift_en, frame_load, err_pulse;
    logic miss_clr, miss_inc;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH)
    ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (slot_adv),
        .load1 (slot_load1),
        .clr   (slot_clr),
        .slot  (slot),
        .last  (slot_last)
    );

    assign slot_zero     = (slot == '0);
    // This miss is the one that brings the count up to MISS_LIMIT.
    assign miss_at_limit = (miss_cnt == MISS_W'(MISS_LIMIT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                HUNT:    if (sync) state_nxt = LOCKED;
                LOCKED:  if (slot_zero && !sync && miss_at_limit) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Output/control logic.
    always_comb begin
        slot_adv   = 1'b0;
        slot_load1 = 1'b0;
        slot_clr   = 1'b0;
        shift_en   = 1'b0;
        frame_load = 1'b0;
        err_pulse  = 1'b0;
        miss_clr   = 1'b0;
        miss_inc   = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        shift_en   = 1'b1;
                        slot_load1 = 1'b1;
                        miss_clr   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (sync && !slot_zero) begin
                        // Misplaced sync: drop the partial frame (including a
                        // would-be completion) and restart with this bit as ch0.
                        err_pulse  = 1'b1;
                        shift_en   = 1'b1;
                        slot_load1 = 1'b1;
                        miss_clr   = 1'b1;
                    end else if (slot_zero) begin
                        if (sync) begin
                            miss_clr = 1'b1;
                            shift_en = 1'b1;
                            slot_adv = 1'b1;
                        end else if (miss_at_limit) begin
                            // Too many missing syncs: bit discarded, back to hunting.
                            slot_clr = 1'b1;
                            miss_clr = 1'b1;
                        end else begin
                            // Flywheel: keep the bit as ch0 and carry on.
                            miss_inc = 1'b1;
                            shift_en = 1'b1;
                            slot_adv = 1'b1;
                        end
                    end else begin
                        shift_en   = 1'b1;
                        slot_adv   = 1'b1;
                        frame_load = slot_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // New bits enter at the top and move down, so after NUM_CH-1 shifts ch0
    // sits at bit 0 and the word lines up with q's channel order.
    always_comb begin
        sr_shifted             = sr >> 1;
        sr_shifted[NUM_CH-2]   = data;
    end

    // NOTE: the frame storage is a handful of flops, so it is reset along with
    // everything else rather than left uninitialised like a RAM would be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt    <= '0;
            sr          <= '0;
            q           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            if (miss_clr) begin
                miss_cnt <= '0;
            end else if (miss_inc) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (shift_en) begin
                sr <= sr_shifted;
            end
            if (frame_load) begin
                q <= {data, sr};
            end
            frame_valid <= frame_load;
            sync_err    <= err_pulse;
        end
    end

    // state is a register, so locked has no combinational path from inputs.
    assign locked = (state == LOCKED);

endmodule
